neg_edge_detector: RTL and testbench

// - Falling-edge (1->0) detector on a synchronous input A, one per bit of a

---
 rtl/neg_edge_detector.sv | 94 +++++++++
 tb/tb_neg_edge_detector.sv | 127 ++++++++++++
 2 files changed

// File: rtl/neg_edge_detector.sv
// Per-bit falling-edge detector with a registered Moore pulse and a
// combinational Mealy pulse side by side. R is an asynchronous active-low reset.
module neg_edge_detector #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             R,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Q_moore,
    output logic [WIDTH-1:0] Q_mealy
);

    typedef enum logic [1:0] {
        M_LOW  = 2'b00,
        M_HIGH = 2'b01,
        M_FALL = 2'b10
    } moore_state_e;

    typedef enum logic {
        E_LOW  = 1'b0,
        E_HIGH = 1'b1
    } mealy_state_e;

    moore_state_e moore_q [WIDTH];
    moore_state_e moore_d [WIDTH];
    mealy_state_e mealy_q [WIDTH];
    mealy_state_e mealy_d [WIDTH];

    // State registers for both detector flavours, cleared asynchronously.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            for (int i = 0; i < WIDTH; i++) begin
                moore_q[i] <= M_LOW;
                mealy_q[i] <= E_LOW;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                moore_q[i] <= moore_d[i];
                mealy_q[i] <= mealy_d[i];
            end
        end
    end

    // Next-state logic for the three-state Moore detector; the unused code returns to LOW.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            moore_d[i] = M_LOW;
            case (moore_q[i])
                M_LOW: begin
                    if (A[i]) moore_d[i] = M_HIGH;
                    else      moore_d[i] = M_LOW;
                end
                M_HIGH: begin
                    if (A[i]) moore_d[i] = M_HIGH;
                    else      moore_d[i] = M_FALL;
                end
                M_FALL: begin
                    if (A[i]) moore_d[i] = M_HIGH;
                    else      moore_d[i] = M_LOW;
                end
                default: moore_d[i] = M_LOW;
            endcase
        end
    end

    // Next-state logic for the two-state Mealy detector.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            mealy_d[i] = E_LOW;
            case (mealy_q[i])
                E_LOW: begin
                    if (A[i]) mealy_d[i] = E_HIGH;
                    else      mealy_d[i] = E_LOW;
                end
                E_HIGH: begin
                    if (A[i]) mealy_d[i] = E_HIGH;
                    else      mealy_d[i] = E_LOW;
                end
                default: mealy_d[i] = E_LOW;
            endcase
        end
    end

    // Output decode: Moore from state only, Mealy also looks at the live input.
    always_comb begin
        Q_moore = {WIDTH{1'b0}};
        Q_mealy = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            Q_moore[i] = (moore_q[i] == M_FALL);
            Q_mealy[i] = (mealy_q[i] == E_HIGH) & ~A[i];
        end
    end

endmodule

// File: tb/tb_neg_edge_detector.sv
// Scoreboard bench for neg_edge_detector (WIDTH=4): stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares them.
module tb_neg_edge_detector;

    localparam int W = 4;

    typedef struct {
        int           id;
        logic [W-1:0] moore;
        logic [W-1:0] mealy;
    } exp_t;

    logic         clk = 1'b0;
    logic         R;
    logic [W-1:0] A;
    logic [W-1:0] Q_moore;
    logic [W-1:0] Q_mealy;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   step_id = 0;

    neg_edge_detector #(.WIDTH(W)) dut (
        .clk    (clk),
        .R      (R),
        .A      (A),
        .Q_moore(Q_moore),
        .Q_mealy(Q_mealy)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per cycle, checked mid-cycle on the falling clock.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (Q_moore !== e.moore) begin
                n_miss++;
                $display("FAIL step%0d q_moore: got %b expected %b", e.id, Q_moore, e.moore);
            end
            if (Q_mealy !== e.mealy) begin
                n_miss++;
                $display("FAIL step%0d q_mealy: got %b expected %b", e.id, Q_mealy, e.mealy);
            end
        end
    end

    // Apply inputs just after a rising edge and queue what the monitor must see.
    task automatic step(input logic [W-1:0] a, input logic r,
                        input logic [W-1:0] em, input logic [W-1:0] ee);
        exp_t e;
        @(posedge clk);
        #1;
        A = a;
        R = r;
        e.id = step_id;
        e.moore = em;
        e.mealy = ee;
        exp_q.push_back(e);
        step_id++;
    endtask

    initial begin
        R = 1'b0;
        A = 4'h0;
        // power-on reset, then release
        step(4'h0, 1'b0, 4'h0, 4'h0);
        step(4'h0, 1'b0, 4'h0, 4'h0);
        step(4'h0, 1'b1, 4'h0, 4'h0);
        // rise and hold: no pulse
        step(4'hF, 1'b1, 4'h0, 4'h0);
        step(4'hF, 1'b1, 4'h0, 4'h0);
        step(4'hF, 1'b1, 4'h0, 4'h0);
        step(4'hF, 1'b1, 4'h0, 4'h0);
        // async reset from HIGH with A falling at the same moment
        step(4'h0, 1'b0, 4'h0, 4'h0);
        step(4'hF, 1'b0, 4'h0, 4'h0);
        step(4'hF, 1'b0, 4'h0, 4'h0);
        step(4'hF, 1'b1, 4'h0, 4'h0);
        // single fall after two high cycles
        step(4'hF, 1'b1, 4'h0, 4'h0);
        step(4'h0, 1'b1, 4'h0, 4'hF);
        step(4'h0, 1'b1, 4'hF, 4'h0);
        step(4'h0, 1'b1, 4'h0, 4'h0);
        step(4'h0, 1'b1, 4'h0, 4'h0);
        // 1,0,1,0 toggling
        step(4'hF, 1'b1, 4'h0, 4'h0);
        step(4'h0, 1'b1, 4'h0, 4'hF);
        step(4'hF, 1'b1, 4'hF, 4'h0);
        step(4'h0, 1'b1, 4'h0, 4'hF);
        step(4'h0, 1'b1, 4'hF, 4'h0);
        step(4'h0, 1'b1, 4'h0, 4'h0);
        // reset while the Moore pulse is up
        step(4'hF, 1'b1, 4'h0, 4'h0);
        step(4'h0, 1'b1, 4'h0, 4'hF);
        step(4'h0, 1'b0, 4'h0, 4'h0);
        step(4'h0, 1'b0, 4'h0, 4'h0);
        step(4'h0, 1'b1, 4'h0, 4'h0);
        step(4'h0, 1'b1, 4'h0, 4'h0);
        step(4'h0, 1'b1, 4'h0, 4'h0);
        // per-bit pattern 1111 -> 0101
        step(4'hF, 1'b1, 4'h0, 4'h0);
        step(4'hF, 1'b1, 4'h0, 4'h0);
        step(4'h5, 1'b1, 4'h0, 4'hA);
        step(4'h5, 1'b1, 4'hA, 4'h0);
        step(4'h5, 1'b1, 4'h0, 4'h0);
        // channel independence: opposite bits fall on different cycles
        step(4'hA, 1'b1, 4'h0, 4'h5);
        step(4'hA, 1'b1, 4'h5, 4'h0);
        step(4'h0, 1'b1, 4'h0, 4'hA);
        step(4'h0, 1'b1, 4'hA, 4'h0);
        step(4'h0, 1'b1, 4'h0, 4'h0);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
